// File: rtl/reaction_timer.sv
// Reaction timer: watches an F1 start-light bar, times lights-out to the first
// trigger press in en ticks, and flags presses made before lights out.
module reaction_timer #(
   parameter int WIDTH     = 8,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [WIDTH-1:0]     lights,
   input  logic                 trigger,
   output logic [CNT_WIDTH-1:0] time_out,
   output logic                 valid,
   output logic                 false_start,
   output logic                 busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LIGHTING,
      S_FULL,
      S_TIMING,
      S_DONE,
      S_FAULT
   } state_t;

   localparam logic [WIDTH-1:0]     ALL_ON  = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   state_t               state_q;
   logic                 trig_q;
   logic [CNT_WIDTH-1:0] counter_q;
   logic [CNT_WIDTH-1:0] time_out_q;
   logic                 valid_q;
   logic                 false_start_q;
   logic                 busy_q;
   logic                 press;

   // Only a rising edge counts; a button held across states is never a press.
   assign press = trigger & ~trig_q;

   // NOTE: every register here is state, so all updates use non-blocking
   // assignments and the reset branch clears them asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         trig_q        <= 1'b0;
         counter_q     <= '0;
         time_out_q    <= '0;
         valid_q       <= 1'b0;
         false_start_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         trig_q <= trigger;
         case (state_q)
            S_IDLE: begin
               if (lights != '0) begin
                  state_q <= S_LIGHTING;
                  busy_q  <= 1'b1;
               end
            end
            S_LIGHTING: begin
               if (press) begin
                  state_q       <= S_FAULT;
                  false_start_q <= 1'b1;
                  valid_q       <= 1'b0;
                  busy_q        <= 1'b0;
               end else if (lights == ALL_ON) begin
                  state_q <= S_FULL;
               end else if (lights == '0) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            S_FULL: begin
               // A press on the lights-out edge itself is still a false start.
               if (press) begin
                  state_q       <= S_FAULT;
                  false_start_q <= 1'b1;
                  valid_q       <= 1'b0;
                  busy_q        <= 1'b0;
               end else if (lights == '0) begin
                  state_q   <= S_TIMING;
                  counter_q <= '0;
               end
            end
            S_TIMING: begin
               if (press) begin
                  state_q    <= S_DONE;
                  time_out_q <= counter_q;
                  valid_q    <= 1'b1;
                  busy_q     <= 1'b0;
               end else if (en && (counter_q != CNT_MAX)) begin
                  counter_q <= counter_q + 1'b1;
               end
            end
            S_DONE: begin
               if (lights != '0) begin
                  state_q <= S_LIGHTING;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            S_FAULT: begin
               if ((lights == '0) && !trigger) begin
                  state_q       <= S_IDLE;
                  false_start_q <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign time_out    = time_out_q;
   assign valid       = valid_q;
   assign false_start = false_start_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Bench for reaction_timer: directed rounds plus randomized rounds, with a
// 16-bit and a 4-bit counter instance checked against a round-level model.
module tb_reaction_timer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       trigger = 1'b0;
   logic [7:0] lights = '0;

   logic [15:0] t16;
   logic        v16, f16, b16;
   logic [3:0]  t4;
   logic        v4, f4, b4;

   always #5 clk = ~clk;

   reaction_timer #(.WIDTH(8), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .en(en), .lights(lights), .trigger(trigger),
      .time_out(t16), .valid(v16), .false_start(f16), .busy(b16)
   );

   reaction_timer #(.WIDTH(8), .CNT_WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .en(en), .lights(lights), .trigger(trigger),
      .time_out(t4), .valid(v4), .false_start(f4), .busy(b4)
   );

   // Round-level view: armed = lights sequence in progress, full = all lamps seen.
   typedef struct {
      bit          armed;
      bit          full;
      bit          timing;
      bit          fault;
      bit          have;
      bit          ptrig;
      int unsigned ticks;
      int unsigned result;
   } model_t;

   model_t      m [2];
   int unsigned cmax [2] = '{65535, 15};

   int errors = 0;
   int checks = 0;
   int en_period = 0;
   int cyc = 0;

   task automatic check(input string tag, input longint unsigned act, input longint unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) m[i] = '{default: 0};
   endtask

   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         bit press;
         press = trigger && !m[i].ptrig;
         if (m[i].fault) begin
            if (lights == 8'h00 && !trigger) m[i].fault = 0;
         end else if (m[i].timing) begin
            if (press) begin
               m[i].result = m[i].ticks;
               m[i].have   = 1;
               m[i].timing = 0;
            end else if (en && m[i].ticks < cmax[i]) begin
               m[i].ticks++;
            end
         end else if (m[i].armed) begin
            if (press) begin
               m[i].fault = 1;
               m[i].armed = 0;
               m[i].full  = 0;
               m[i].have  = 0;
            end else if (!m[i].full && lights == 8'hFF) begin
               m[i].full = 1;
            end else if (lights == 8'h00) begin
               if (m[i].full) begin
                  m[i].timing = 1;
                  m[i].ticks  = 0;
               end
               m[i].armed = 0;
               m[i].full  = 0;
            end
         end else if (lights != 8'h00) begin
            m[i].armed = 1;
            m[i].have  = 0;
         end
         m[i].ptrig = trigger;
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".time16"},  t16, m[0].result);
      check({tag, ".valid16"}, v16, m[0].have);
      check({tag, ".fs16"},    f16, m[0].fault);
      check({tag, ".busy16"},  b16, m[0].armed || m[0].timing);
      check({tag, ".time4"},   t4,  m[1].result);
      check({tag, ".valid4"},  v4,  m[1].have);
      check({tag, ".fs4"},     f4,  m[1].fault);
      check({tag, ".busy4"},   b4,  m[1].armed || m[1].timing);
   endtask

   // Inputs are set at the falling edge, consumed at the rising edge, checked at the next fall.
   task automatic cycle(input string tag = "cyc");
      if (en_period > 0) en = (cyc % en_period) == 0;
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      cyc++;
      @(negedge clk);
      compare_all(tag);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) cycle();
   endtask

   task automatic async_reset(input string tag);
      #2 rst = 1'b1;
      #1;
      model_reset();
      compare_all(tag);
      @(negedge clk);
      cycle({tag, ".hold"});
      rst = 1'b0;
   endtask

   task automatic fill_lights(input int hold);
      for (int k = 0; k < 8; k++) begin
         lights = 8'((9'h1 << (k + 1)) - 1);
         repeat (hold) cycle("fill");
      end
   endtask

   initial begin
      int n;
      @(negedge clk);

      // 1: asynchronous reset without a clock edge, then idle
      async_reset("t1_rst");
      lights = 8'h00;
      idle_cycles(3);
      check("t1_busy", b16, 0);

      // 2: normal round, en every 4th cycle, press 40 cycles after lights out
      en_period = 4;
      fill_lights(2);
      lights = 8'h00;
      cycle("t2_out");
      idle_cycles(40);
      trigger = 1'b1;
      cycle("t2_press");
      check("t2_time", t16, 10);
      check("t2_valid", v16, 1);
      check("t2_busy", b16, 0);
      trigger = 1'b0;
      idle_cycles(5);
      check("t2_hold_time", t16, 10);
      check("t2_hold_valid", v16, 1);

      // 3: false start at 0x07, trigger held through lights out
      lights = 8'h01; cycle();
      lights = 8'h03; cycle();
      lights = 8'h07; cycle();
      trigger = 1'b1;
      cycle("t3_press");
      check("t3_fs", f16, 1);
      check("t3_valid", v16, 0);
      lights = 8'h00;
      idle_cycles(3);
      check("t3_fs_held", f16, 1);
      trigger = 1'b0;
      cycle("t3_release");
      check("t3_fs_clear", f16, 0);
      check("t3_busy", b16, 0);

      // 4: button held since idle, released after lights out, re-pressed after 6 ticks
      en_period = 0;
      en = 1'b0;
      trigger = 1'b1;
      idle_cycles(2);
      fill_lights(1);
      lights = 8'h00;
      cycle("t4_out");
      trigger = 1'b0;
      cycle();
      for (int i = 0; i < 6; i++) begin
         en = 1'b1; cycle();
         en = 1'b0; cycle();
      end
      trigger = 1'b1;
      cycle("t4_press");
      check("t4_time", t16, 6);
      check("t4_fs", f16, 0);
      trigger = 1'b0;
      idle_cycles(2);

      // 5a: saturation of the 4-bit counter
      en_period = 1;
      fill_lights(1);
      lights = 8'h00;
      cycle("t5_out");
      idle_cycles(30);
      trigger = 1'b1;
      cycle("t5_press");
      check("t5_sat4", t4, 15);
      check("t5_time16", t16, 30);
      trigger = 1'b0;
      idle_cycles(2);

      // 5b: press on the same edge as en with counter at 5
      fill_lights(1);
      lights = 8'h00;
      cycle("t5b_out");
      idle_cycles(5);
      trigger = 1'b1;
      cycle("t5b_press");
      check("t5b_time16", t16, 5);
      check("t5b_time4", t4, 5);
      trigger = 1'b0;
      idle_cycles(2);

      // 6: reset in the middle of timing, then lights out and a press give nothing
      fill_lights(1);
      lights = 8'h00;
      cycle("t6_out");
      idle_cycles(9);
      async_reset("t6_rst");
      check("t6_time", t16, 0);
      idle_cycles(3);
      trigger = 1'b1;
      cycle("t6_press");
      check("t6_valid", v16, 0);
      check("t6_busy", b16, 0);
      trigger = 1'b0;
      idle_cycles(2);

      // Randomized rounds with aborts, partial patterns, stray presses and resets
      for (int r = 0; r < 80; r++) begin
         en_period = $urandom_range(1, 5);
         for (int k = 0; k < 8; k++) begin
            lights = 8'((9'h1 << (k + 1)) - 1);
            repeat ($urandom_range(1, 3)) begin
               if ($urandom_range(0, 99) < 3) trigger = ~trigger;
               cycle("rnd_fill");
            end
            if ($urandom_range(0, 19) == 0) begin
               lights = 8'h00;
               break;
            end
         end
         if ($urandom_range(0, 3) == 0) begin
            lights = 8'($urandom);
            cycle("rnd_partial");
         end
         lights = 8'h00;
         n = $urandom_range(0, 40);
         repeat (n) begin
            if ($urandom_range(0, 99) < 5) trigger = ~trigger;
            lights = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h00;
            cycle("rnd_wait");
         end
         lights = 8'h00;
         trigger = 1'b0;
         cycle("rnd_low");
         trigger = 1'b1;
         cycle("rnd_press");
         cycle("rnd_after");
         if ($urandom_range(0, 7) == 0) async_reset("rnd_rst");
         trigger = 1'b0;
         idle_cycles(2);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reaction_timer.md
Name: reaction_timer

Overview:
- Downstream consumer of the F1 start-light sequencer output (8-bit light bar, filled one lamp at a time, then all lamps off at once).
- Watches the light bar and measures player reaction time in tick units from "lights out" to the first trigger press.
- Flags a false start when the trigger is pressed before lights out.
- Shares the same en tick source (typically a 1 ms clktick pulse) as the light sequencer.

Parameters:
- WIDTH, 8, light bar width; all-on pattern is all ones.
- CNT_WIDTH, 16, reaction counter and result width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  one-cycle tick pulse; the reaction counter advances only on cycles where en=1.
- lights  input  WIDTH  light bar from the sequencer.
- trigger  input  1  player button; already synchronised and debounced, level-sensitive.
- time_out  output  CNT_WIDTH  last captured reaction time, in ticks.
- valid  output  1  time_out holds a result from the current round.
- false_start  output  1  trigger was pressed before lights out.
- busy  output  1  a round is in progress.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. On rst=1, immediately and without a clock edge:
  - state=IDLE
  - counter=0, time_out=0
  - valid=0, false_start=0, busy=0
  - trig_q=0
- Trigger edge detection:
  - trig_q is trigger registered by one cycle.
  - press = trigger & ~trig_q.
  - A held button never counts as a press; only a rising edge does.
- All outputs are registered. busy=1 in LIGHTING, FULL and TIMING; 0 otherwise.
- States and transitions, evaluated each rising edge:
  - IDLE:
    - lights!=0 -> LIGHTING.
    - press is ignored.
  - LIGHTING:
    - press -> FAULT (press has priority over light changes).
    - lights==all ones -> FULL.
    - lights==0 -> IDLE (aborted sequence, no result).
  - FULL:
    - press -> FAULT.
    - lights==0 -> TIMING, counter<=0.
    - A partial-lights pattern after FULL stays in FULL.
  - TIMING:
    - press -> DONE, time_out<=counter (the value before any increment on that edge), valid<=1.
    - Otherwise, if en=1, counter<=counter+1, saturating at 2^CNT_WIDTH-1 (no wrap).
    - lights!=0 while TIMING is ignored; the state stays TIMING.
  - DONE:
    - time_out and valid hold.
    - lights!=0 -> LIGHTING, valid<=0, time_out unchanged.
  - FAULT:
    - false_start=1 while in FAULT.
    - When lights==0 and trigger==0 -> IDLE, false_start<=0.
    - valid<=0 on entry; time_out unchanged.
- Latency: press sampled at edge k means valid=1 and the new time_out are visible after edge k. Reaction time = number of en pulses seen in TIMING before the press edge.
- Simultaneous events:
  - en and press on the same edge: capture the un-incremented value.
  - press on the same edge that lights go to 0 while in FULL: counts as a false start (-> FAULT).
- Entering a new round (LIGHTING from IDLE or DONE) does not clear time_out.

Test Plan:
1. Reset: assert rst mid-cycle with no clock edge -> all outputs 0 immediately. Release rst, hold lights=0 -> state IDLE, busy=0.
2. Normal round (en every 4th cycle): lights 0x01,0x03,...,0xFF, then 0x00; trigger rises 40 cycles after lights=0 -> time_out=10, valid=1 on the next edge. busy=0 afterwards; both outputs hold until lights!=0.
3. False start: trigger rises while lights=0x07 -> false_start=1, valid=0. Then lights->0 with trigger still high -> false_start stays 1; trigger low -> false_start=0, state IDLE.
4. Held button: trigger held high from FULL through lights out, released and re-pressed after 6 en pulses -> no false start; time_out=6.
5. Saturation and simultaneity:
   - CNT_WIDTH=4, en every cycle, no press for 30 cycles after lights out, then press -> time_out=15.
   - Second run: press on the same edge as en with counter=5 -> time_out=5.
6. Mid-operation reset: rst pulse during TIMING with counter=9 -> time_out=0, valid=0, busy=0 at once. A following lights=0x00 does not start timing; a later press gives no result.
